mips_multicycle_ctrl: RTL

Main control FSM for the multicycle MIPS datapath. It decodes the opcode from the instruction register and sequences every datapath resource, cycle by cycle: PC, memory port, IR, register file, ALU muxes, and the registered 16→32 sign extender. The sequence accounts for the extender's one-cycle registered latency. The block stalls on a memory-ready handshake and drives all write enables and mux selects.

---
 rtl/mips_ctrl_pkg.sv | 75 +++++++
 rtl/mips_ctrl_outdec.sv | 90 +++++++++
 rtl/mips_multicycle_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller:
// state encoding, opcodes, datapath select codes and the control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BR_TGT   = 4'd8,
        S_BR_CMP   = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_EXT     = 2'b10;
    localparam logic [1:0] SRCB_EXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_zero;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    // andi/ori need the extender in zero-extend mode
    function automatic logic is_logic_imm(logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_known_op(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ)  ||
               (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_ORI)   || (op == OP_LW)   || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State to control-word decode. Moore outputs, with FETCH write enables
// qualified by mem_ready and every enable suppressed while reset is high.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       reset,
    output ctrl_t      ctrl_c
);

    always_comb begin
        ctrl_c           = '0;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_src    = PCSRC_ALU;

        case (state)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // extender samples its mode at the end of this cycle
                ctrl_c.ext_zero   = is_logic_imm(opcode);
                ctrl_c.illegal_op = !is_known_op(opcode);
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_EXT;
            end
            S_MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            S_BR_TGT: begin
                ctrl_c.alu_src_b = SRCB_EXT_SH2;
            end
            S_BR_CMP: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_op        = ALU_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_src        = PCSRC_ALUOUT;
                ctrl_c.branch_ne     = opcode[0];
            end
            S_IMM_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_EXT;
                ctrl_c.ext_zero  = is_logic_imm(opcode);
                if (is_logic_imm(opcode)) begin
                    ctrl_c.alu_op = ALU_LOGIC;
                end
            end
            S_IMM_WB: begin
                ctrl_c.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_write = 1'b1;
                ctrl_c.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase

        // reset shows FETCH selects with every enable off
        if (reset) begin
            ctrl_c           = '0;
            ctrl_c.alu_src_b = SRCB_FOUR;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences PC, memory,
// IR, register file and ALU muxes, stalling on the memory-ready handshake.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_zero,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state;
    ctrl_t  ctrl;

    // opcode is only consulted in DECODE and MEMADR; IR is stable after FETCH
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:           state <= S_MEMADR;
                        OP_RTYPE:               state <= S_RTYPE_EX;
                        OP_BEQ, OP_BNE:         state <= S_BR_TGT;
                        OP_ADDI, OP_ANDI, OP_ORI: state <= S_IMM_EX;
                        OP_J:                   state <= S_JUMP;
                        default:                state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode == OP_LW) state <= S_MEMRD;
                    else                 state <= S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (mem_ready) state <= S_FETCH;
                end
                S_RTYPE_EX: state <= S_RTYPE_WB;
                S_BR_TGT:   state <= S_BR_CMP;
                S_IMM_EX:   state <= S_IMM_WB;
                // write-back/terminal states and unused encodings restart
                default:    state <= S_FETCH;
            endcase
        end
    end

    mips_ctrl_outdec u_outdec (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .reset     (reset),
        .ctrl_c    (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign ext_zero      = ctrl.ext_zero;
    assign pc_src        = ctrl.pc_src;
    assign illegal_op    = ctrl.illegal_op;
    assign state_o       = state;

endmodule
